serial_magnitude_comparator: RTL and testbench

Parametrised, digit-serial magnitude comparator, the successor to our 4-bit combinational comparator. It captures two WIDTH-bit operands on a START handshake and compares them DIGIT bits per cycle, MSB digit first. It supports unsigned and two's-complement modes and optional early exit. Results use the existing 2-bit OUT code plus a per-bit equality vector X. It sits beside datapath blocks that need wide compares without a wide combinational carry chain.

---
 rtl/cmp_pkg.sv | 22 ++
 rtl/digit_compare.sv | 33 +++
 rtl/serial_magnitude_comparator.sv | 145 ++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// Shared definitions for the digit-serial magnitude comparator.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cmp_pkg;

  // Result codes on the 2-bit OUT bus. The value 2'b11 is never produced.
  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Maps a decided (unequal) digit to its result code.
  function automatic logic [1:0] cmp_code(input logic gt);
    return gt ? CMP_GT : CMP_LT;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// One-digit magnitude compare; the MSB digit can be treated as two's complement.
// Latency: purely combinational.
// Backpressure: none.
// Ports:
//   a, b          : digit slices of operand A and operand B
//   is_msb_signed : this is the top digit of a signed compare
//   eq            : a == b
//   gt            : a > b (only meaningful when eq is low)
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             is_msb_signed,
  output logic             eq,
  output logic             gt
);

  logic sign_differs;

  assign eq           = (a == b);
  assign sign_differs = a[DIGIT-1] ^ b[DIGIT-1];

  // With differing sign bits in a signed top digit, the operand whose sign
  // bit is 0 (non-negative) is the larger one. Otherwise plain unsigned order.
  always_comb begin
    gt = (a > b);
    if (is_msb_signed && sign_differs) begin
      gt = b[DIGIT-1];
    end
  end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Digit-serial magnitude comparator: captures two operands and compares them MSB digit first.
// Latency: done pulses 1..NUM_DIGITS cycles after acceptance (always NUM_DIGITS without early exit).
// Backpressure: start is only sampled when not busy; a start during a run is dropped.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, signed_mode  : request and its compare mode, sampled together
//   in1, in2            : operands, captured on the accepting edge
//   busy, done          : running flag, single-cycle completion pulse
//   out, x              : result code, bitwise XNOR of the captured operands
module serial_magnitude_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             busy,
  output logic             done,
  output logic [1:0]       out,
  output logic [WIDTH-1:0] x
);

  localparam int NUM_DIGITS = WIDTH / DIGIT;
  localparam int CW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NUM_DIGITS - 1);

  generate
    if ((WIDTH < DIGIT) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
      $error("serial_magnitude_comparator: WIDTH must be a non-zero multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             sgn_q;
  logic [CW-1:0]    cnt;
  logic             decided;   // an unequal digit has already been seen
  logic [1:0]       res_q;     // result of the first unequal digit

  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             dig_eq;
  logic             dig_gt;
  logic             msb_signed;

  // Single shared digit comparator, fed by a counter-driven mux.
  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cnt == CW'(i)) begin
        dig_a = a_q[i*DIGIT +: DIGIT];
        dig_b = b_q[i*DIGIT +: DIGIT];
      end
    end
  end

  // Sign handling only matters on the top digit.
  assign msb_signed = sgn_q && (cnt == LAST_DIGIT);

  digit_compare #(
    .DIGIT(DIGIT)
  ) u_digit_compare (
    .a            (dig_a),
    .b            (dig_b),
    .is_msb_signed(msb_signed),
    .eq           (dig_eq),
    .gt           (dig_gt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      out     <= CMP_EQ;
      x       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      cnt     <= '0;
      decided <= 1'b0;
      res_q   <= CMP_EQ;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q     <= in1;
            b_q     <= in2;
            sgn_q   <= signed_mode;
            x       <= in1 ~^ in2;
            cnt     <= LAST_DIGIT;
            decided <= 1'b0;
            res_q   <= CMP_EQ;
            busy    <= 1'b1;
            state   <= ST_RUN;
          end else if (state == ST_DONE) begin
            state <= ST_IDLE;
          end
        end

        ST_RUN: begin
          if (!dig_eq && EARLY_EXIT) begin
            out   <= cmp_code(dig_gt);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else if (cnt == '0) begin
            // Last digit: an earlier decision wins; otherwise this digit decides.
            if (decided) begin
              out <= res_q;
            end else if (!dig_eq) begin
              out <= cmp_code(dig_gt);
            end else begin
              out <= CMP_EQ;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
            if (!dig_eq && !decided) begin
              decided <= 1'b1;
              res_q   <= cmp_code(dig_gt);
            end
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Bench for serial_magnitude_comparator: one early-exit and one constant-latency instance.
// Latency: expected done cycle is predicted per request from a reference model.
// Backpressure: start issued during a run is expected to be ignored.
module tb_serial_magnitude_comparator;
  import cmp_pkg::*;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int ND = W / D;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         sgn;
  logic [W-1:0] in1;
  logic [W-1:0] in2;

  logic         busy1, done1, busy0, done0;
  logic [1:0]   out1, out0;
  logic [W-1:0] x1, x0;

  serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sgn),
    .in1(in1), .in2(in2), .busy(busy1), .done(done1), .out(out1), .x(x1)
  );

  serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1'b0)) dut_cl (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(sgn),
    .in1(in1), .in2(in2), .busy(busy0), .done(done0), .out(out0), .x(x0)
  );

  typedef struct {
    logic [1:0]   out;
    logic [W-1:0] x;
    int           cyc;
    int           k;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  exp_t e1, e0;

  int cyc     = 0;
  int n_pass  = 0;
  int n_total = 0;
  int bc1     = 0;
  int bc0     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [1:0] model_out(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    if (s) begin
      if ($signed(a) > $signed(b)) return CMP_GT;
      if ($signed(a) < $signed(b)) return CMP_LT;
      return CMP_EQ;
    end
    if (a > b) return CMP_GT;
    if (a < b) return CMP_LT;
    return CMP_EQ;
  endfunction

  // Digits examined: up to and including the highest digit holding a differing bit.
  function automatic int model_k(input logic [W-1:0] a, input logic [W-1:0] b, input bit ee);
    logic [W-1:0] d;
    d = a ^ b;
    if (!ee || d == '0) return ND;
    for (int i = W - 1; i >= 0; i--) begin
      if (d[i]) return ND - i / D;
    end
    return ND;
  endfunction

  // Called on a falling edge; returns 1 ns after the accepting rising edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    in1   = a;
    in2   = b;
    sgn   = s;
    start = 1'b1;
    e.out = model_out(a, b, s);
    e.x   = ~(a ^ b);
    e.k   = model_k(a, b, 1'b1);
    e.cyc = cyc + 1 + e.k;
    q1.push_back(e);
    e.k   = model_k(a, b, 1'b0);
    e.cyc = cyc + 1 + e.k;
    q0.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q1.size() + q0.size()) != 0; i++) @(negedge clk);
    chk("drain_pending", 32'(q1.size() + q0.size()), 32'd0);
  endtask

  // Scoreboard: every done pulse pops one expectation and checks result and timing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy1) bc1++;
      if (busy0) bc0++;
      if (done1) begin
        chk("ee_done_expected", 32'(q1.size() != 0), 32'd1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("ee_out", 32'(out1), 32'(e1.out));
          chk("ee_x", 32'(x1), 32'(e1.x));
          chk("ee_latency_cycle", cyc, e1.cyc);
          chk("ee_busy_cycles", bc1, e1.k);
        end
        bc1 = 0;
      end
      if (done0) begin
        chk("cl_done_expected", 32'(q0.size() != 0), 32'd1);
        if (q0.size() != 0) begin
          e0 = q0.pop_front();
          chk("cl_out", 32'(out0), 32'(e0.out));
          chk("cl_x", 32'(x0), 32'(e0.x));
          chk("cl_latency_cycle", cyc, e0.cyc);
          chk("cl_busy_cycles", bc0, e0.k);
        end
        bc0 = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    in1   = '0;
    in2   = '0;
    #1 rst_n = 1'b0;
    #10;
    chk("rst_ee_busy", 32'(busy1), 32'd0);
    chk("rst_ee_done", 32'(done1), 32'd0);
    chk("rst_ee_out", 32'(out1), 32'(CMP_EQ));
    chk("rst_ee_x", 32'(x1), 32'd0);
    chk("rst_cl_busy", 32'(busy0), 32'd0);
    chk("rst_cl_done", 32'(done0), 32'd0);
    chk("rst_cl_out", 32'(out0), 32'(CMP_EQ));
    chk("rst_cl_x", 32'(x0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);

    // Equal operands: every digit examined.
    launch(16'h1234, 16'h1234, 1'b0);
    drain();

    // Top digit decides; signed mode flips the answer.
    launch(16'hF000, 16'h0FFF, 1'b0);
    drain();
    launch(16'hF000, 16'h0FFF, 1'b1);
    drain();

    // Decision in an upper digit, then in the last digit.
    launch(16'h1000, 16'h0FFF, 1'b0);
    drain();
    launch(16'h0001, 16'h0002, 1'b0);
    drain();

    // Back-to-back: next request issued in the done cycle.
    launch(16'h0003, 16'h0007, 1'b0);
    for (int i = 0; i < 20 && !done1; i++) @(negedge clk);
    chk("b2b_first_done_seen", 32'(done1), 32'd1);
    launch(16'h0005, 16'h0005, 1'b0);
    drain();

    // Start during a run, with different operands, must be ignored.
    launch(16'h1234, 16'h1235, 1'b0);
    @(negedge clk);
    in1   = 16'hFFFF;
    in2   = 16'h0000;
    sgn   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();

    // Asynchronous reset in the second run cycle aborts the operation.
    launch(16'h0001, 16'h0002, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_ee_busy", 32'(busy1), 32'd0);
    chk("arst_ee_done", 32'(done1), 32'd0);
    chk("arst_ee_out", 32'(out1), 32'(CMP_EQ));
    chk("arst_ee_x", 32'(x1), 32'd0);
    chk("arst_cl_busy", 32'(busy0), 32'd0);
    chk("arst_cl_out", 32'(out0), 32'(CMP_EQ));
    rst_n = 1'b1;
    q1.delete();
    q0.delete();
    bc1 = 0;
    bc0 = 0;
    repeat (10) @(negedge clk);
    chk("arst_ee_still_idle", 32'(busy1), 32'd0);

    // Normal operation after the abort.
    launch(16'h8000, 16'h7FFF, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
